// File: rtl/stage_exe_pipe.sv
// ============================================================================
// stage_exe_pipe : flow-controlled execute stage with a single-cycle ALU and an
// optional radix-2 iterative multiplier (define STAGE_EXE_PIPE_MUL_EN).
// Revision: 1.0
// ============================================================================
`default_nettype none

module stage_exe_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned OP_LSB = 7,
    parameter logic [4:0]  MUL_OP = 5'h1F
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] instruction_in,
    input  logic [WIDTH-1:0] register_a_value,
    input  logic [WIDTH-1:0] register_b_value,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] instruction_out,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] register_a_value_exe_out,
    output logic [WIDTH-1:0] register_b_value_exe_out,
    output logic             busy
);

    localparam int unsigned SHW = $clog2(WIDTH);
    localparam int unsigned CW  = $clog2(WIDTH + 1);

    typedef enum logic [3:0] {
        A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SLL, A_SRL, A_SRA, A_SLT, A_SLTU, A_ZERO
    } alu_ctrl_t;

    logic [4:0]       w_op;
    alu_ctrl_t        w_ctrl;
    logic [WIDTH-1:0] w_alu_y;
    logic [SHW-1:0]   w_shamt;
    logic             w_out_free;
    logic             w_idle;
    logic             w_accept;
    logic             w_is_mul;
    logic             w_mul_wr;
    logic [WIDTH-1:0] w_mul_result;
    logic [WIDTH-1:0] w_mul_instr;
    logic [WIDTH-1:0] w_mul_a;
    logic [WIDTH-1:0] w_mul_b;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_instr_out;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_a_out;
    logic [WIDTH-1:0] r_b_out;

    assign w_op       = instruction_in[OP_LSB +: 5];
    assign w_shamt    = register_b_value[SHW-1:0];
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = w_idle && w_out_free && !flush;
    assign w_accept   = in_valid && in_ready;

    // alu_control: instruction op field to ALU function; unknown codes yield zero
    always_comb begin
        w_ctrl = A_ZERO;
        case (w_op)
            5'd0:    w_ctrl = A_ADD;
            5'd1:    w_ctrl = A_SUB;
            5'd2:    w_ctrl = A_AND;
            5'd3:    w_ctrl = A_OR;
            5'd4:    w_ctrl = A_XOR;
            5'd5:    w_ctrl = A_SLL;
            5'd6:    w_ctrl = A_SRL;
            5'd7:    w_ctrl = A_SRA;
            5'd8:    w_ctrl = A_SLT;
            5'd9:    w_ctrl = A_SLTU;
            default: w_ctrl = A_ZERO;
        endcase
    end

    always_comb begin
        w_alu_y = '0;
        case (w_ctrl)
            A_ADD:   w_alu_y = register_a_value + register_b_value;
            A_SUB:   w_alu_y = register_a_value - register_b_value;
            A_AND:   w_alu_y = register_a_value & register_b_value;
            A_OR:    w_alu_y = register_a_value | register_b_value;
            A_XOR:   w_alu_y = register_a_value ^ register_b_value;
            A_SLL:   w_alu_y = register_a_value << w_shamt;
            A_SRL:   w_alu_y = register_a_value >> w_shamt;
            A_SRA:   w_alu_y = $unsigned($signed(register_a_value) >>> w_shamt);
            A_SLT:   w_alu_y = {{(WIDTH-1){1'b0}},
                                $signed(register_a_value) < $signed(register_b_value)};
            A_SLTU:  w_alu_y = {{(WIDTH-1){1'b0}}, register_a_value < register_b_value};
            default: w_alu_y = '0;
        endcase
    end

`ifdef STAGE_EXE_PIPE_MUL_EN
    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_MUL_BUSY = 2'd1,
        S_MUL_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH-1:0] r_mul_instr;
    logic [WIDTH-1:0] r_mul_a;
    logic [WIDTH-1:0] r_mul_b;
    logic [WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0] r_mplier;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;

    assign w_is_mul     = (w_op == MUL_OP);
    assign w_idle       = (r_state == S_IDLE);
    assign busy         = !w_idle;
    assign w_acc_next   = r_acc + (r_mplier[0] ? r_mcand : '0);
    assign w_mul_wr     = ((r_state == S_MUL_BUSY && r_count == CW'(1)) ||
                           r_state == S_MUL_DONE) && w_out_free;
    // The final step's sum is not in r_acc yet, so forward it when writing directly
    assign w_mul_result = (r_state == S_MUL_DONE) ? r_acc : w_acc_next;
    assign w_mul_instr  = r_mul_instr;
    assign w_mul_a      = r_mul_a;
    assign w_mul_b      = r_mul_b;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_mul_instr <= '0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_is_mul) begin
                        r_mul_instr <= instruction_in;
                        r_mul_a     <= register_a_value;
                        r_mul_b     <= register_b_value;
                        r_mcand     <= register_a_value;
                        r_mplier    <= register_b_value;
                        r_acc       <= '0;
                        r_count     <= CW'(WIDTH);
                        r_state     <= S_MUL_BUSY;
                    end
                end
                S_MUL_BUSY: begin
                    r_acc    <= w_acc_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_state <= w_out_free ? S_IDLE : S_MUL_DONE;
                    end
                end
                S_MUL_DONE: begin
                    if (w_out_free) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
`else
    assign w_is_mul     = 1'b0;
    assign w_idle       = 1'b1;
    assign busy         = 1'b0;
    assign w_mul_wr     = 1'b0;
    assign w_mul_result = '0;
    assign w_mul_instr  = '0;
    assign w_mul_a      = '0;
    assign w_mul_b      = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_instr_out <= '0;
            r_result    <= '0;
            r_a_out     <= '0;
            r_b_out     <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept && !w_is_mul) begin
            r_out_valid <= 1'b1;
            r_instr_out <= instruction_in;
            r_result    <= w_alu_y;
            r_a_out     <= register_a_value;
            r_b_out     <= register_b_value;
        end else if (w_mul_wr) begin
            r_out_valid <= 1'b1;
            r_instr_out <= w_mul_instr;
            r_result    <= w_mul_result;
            r_a_out     <= w_mul_a;
            r_b_out     <= w_mul_b;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid                = r_out_valid;
    assign instruction_out          = r_instr_out;
    assign alu_result               = r_result;
    assign register_a_value_exe_out = r_a_out;
    assign register_b_value_exe_out = r_b_out;

endmodule

`default_nettype wire

// File: tb/tb_stage_exe_pipe.sv
// ============================================================================
// tb_stage_exe_pipe : self-checking bench for stage_exe_pipe (WIDTH = 32).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_stage_exe_pipe;

    localparam logic [4:0] OP_ADD = 5'd0;
    localparam logic [4:0] OP_MUL = 5'h1F;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instruction_in;
    logic [31:0] register_a_value;
    logic [31:0] register_b_value;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instruction_out;
    logic [31:0] alu_result;
    logic [31:0] register_a_value_exe_out;
    logic [31:0] register_b_value_exe_out;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    stage_exe_pipe dut (
        .clk                      (clk),
        .rst                      (rst),
        .flush                    (flush),
        .in_valid                 (in_valid),
        .in_ready                 (in_ready),
        .instruction_in           (instruction_in),
        .register_a_value         (register_a_value),
        .register_b_value         (register_b_value),
        .out_valid                (out_valid),
        .out_ready                (out_ready),
        .instruction_out          (instruction_out),
        .alu_result               (alu_result),
        .register_a_value_exe_out (register_a_value_exe_out),
        .register_b_value_exe_out (register_b_value_exe_out),
        .busy                     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Reference ALU from the op-code table (op field at bits 11:7)
    function automatic logic [31:0] alu_ref(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        case (op)
            5'd0:    r = a + b;
            5'd1:    r = a - b;
            5'd2:    r = a & b;
            5'd3:    r = a | b;
            5'd4:    r = a ^ b;
            5'd5:    r = a << (b % 32);
            5'd6:    r = a >> (b % 32);
            5'd7:    r = 32'($signed(a) >>> (b % 32));
            5'd8:    r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            5'd9:    r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b);
        logic [31:0] w;
        w = $urandom;
        w[11:7] = op;
        in_valid         = v;
        instruction_in   = w;
        register_a_value = a;
        register_b_value = b;
    endtask

    task automatic test_reset;
        logic seen;
        rst = 1'b0; flush = 1'b0; out_ready = 1'b1;
        drive(1'b0, OP_ADD, 32'd0, 32'd0);
        repeat (3) tick;
        n_checks++;
        if ({out_valid, busy, instruction_out, alu_result, register_a_value_exe_out,
             register_b_value_exe_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: valid=%b busy=%b res=%h instr=%h, required all 0",
                     out_valid, busy, alu_result, instruction_out);
        end
        rst = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready: got %b required 1", in_ready);
        end
        // Reset while a result is being held
        drive(1'b1, OP_ADD, 32'd5, 32'd6); out_ready = 1'b0;
        tick; in_valid = 1'b0;
        #1; rst = 1'b0; #1;
        n_checks++;
        if ({out_valid, busy, instruction_out, alu_result, register_a_value_exe_out,
             register_b_value_exe_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_midrun: valid=%b res=%h, required all 0", out_valid, alu_result);
        end
        tick; rst = 1'b1; out_ready = 1'b1; #1;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
`ifdef STAGE_EXE_PIPE_MUL_EN
        drive(1'b1, OP_MUL, $urandom | 32'd1, $urandom | 32'd1);
        tick; in_valid = 1'b0;
        repeat (5) tick;
        rst = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_mul_busy: got %b required 0", busy);
        end
        tick; rst = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL reset_mul_abort: result emitted=%b required 0", seen);
        end
`endif
    endtask

    task automatic test_back_to_back;
        logic [31:0] ei;
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd3, 32'd4); ei = instruction_in;
        tick;
        n_checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd7 || instruction_out !== ei ||
            register_a_value_exe_out !== 32'd3 || register_b_value_exe_out !== 32'd4) begin
            n_fail++;
            $display("FAIL b2b_first: valid=%b res=%0d a=%0d b=%0d required 1/7/3/4",
                     out_valid, alu_result, register_a_value_exe_out, register_b_value_exe_out);
        end
        drive(1'b1, OP_ADD, 32'd10, 32'd20); ei = instruction_in; #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL b2b_ready: got %b required 1", in_ready);
        end
        tick;
        n_checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd30 || instruction_out !== ei ||
            register_a_value_exe_out !== 32'd10 || register_b_value_exe_out !== 32'd20) begin
            n_fail++;
            $display("FAIL b2b_second: valid=%b res=%0d required 1/30", out_valid, alu_result);
        end
        in_valid = 1'b0;
        tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL b2b_drain: out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_backpressure;
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd5, 32'd6);
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (out_valid !== 1'b1 || alu_result !== 32'd11 || in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b res=%0d in_ready=%b required 1/11/0",
                         i, out_valid, alu_result, in_ready);
            end
            tick;
        end
        out_ready = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2); #1;
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release_ready: got %b required 1", in_ready);
        end
        tick;
        n_checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd3) begin
            n_fail++; $display("FAIL bp_next: valid=%b res=%0d required 1/3", out_valid, alu_result);
        end
        in_valid = 1'b0;
        tick;
    endtask

    task automatic test_random_alu;
        logic        m_valid;
        logic [31:0] m_res, m_instr, m_a, m_b;
        logic [4:0]  op;
        logic        exp_ready, acc;
        int          errs;
        m_valid = out_valid; m_res = alu_result; m_instr = instruction_out;
        m_a = register_a_value_exe_out; m_b = register_b_value_exe_out;
        errs = 0;
        for (int c = 0; c < 300; c++) begin
            op = 5'($urandom_range(0, 15));
`ifndef STAGE_EXE_PIPE_MUL_EN
            if ($urandom_range(0, 7) == 0) op = OP_MUL;
`endif
            drive(1'($urandom_range(0, 1)), op, $urandom, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            exp_ready = !m_valid || out_ready;
            n_checks++;
            if (in_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_in_ready c=%0d: got %b required %b", c, in_ready, exp_ready);
            end
            acc = in_valid && exp_ready;
            tick;
            if (acc) begin
                m_valid = 1'b1; m_instr = instruction_in;
                m_a = register_a_value; m_b = register_b_value;
                m_res = alu_ref(op, register_a_value, register_b_value);
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            n_checks++;
            if (out_valid !== m_valid || (m_valid && (alu_result !== m_res ||
                instruction_out !== m_instr || register_a_value_exe_out !== m_a ||
                register_b_value_exe_out !== m_b))) begin
                n_fail++;
                if (errs < 10)
                    $display("FAIL rand_out c=%0d op=%0d: valid=%b res=%h required %b/%h",
                             c, op, out_valid, alu_result, m_valid, m_res);
                errs++;
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        tick;
    endtask

`ifdef STAGE_EXE_PIPE_MUL_EN
    task automatic test_mul;
        logic [31:0] a, b, ep, ei;
        int          cycles;
        logic        bad;
        for (int t = 0; t < 6; t++) begin
            a = (t == 0) ? 32'h0001_0001 : $urandom;
            b = (t == 0) ? 32'h0001_0000 : $urandom;
            ep = a * b;
            out_ready = 1'b1;
            drive(1'b1, OP_MUL, a, b); ei = instruction_in;
            tick;
            in_valid = 1'b0;
            cycles = 0; bad = 1'b0;
            while (busy === 1'b1 && cycles < 100) begin
                cycles++;
                if (out_valid !== 1'b0 || in_ready !== 1'b0) bad = 1'b1;
                tick;
            end
            n_checks++;
            if (cycles != 32 || bad) begin
                n_fail++;
                $display("FAIL mul_latency t=%0d: busy cycles=%0d early_out=%b required 32/0",
                         t, cycles, bad);
            end
            n_checks++;
            if (out_valid !== 1'b1 || alu_result !== ep || instruction_out !== ei ||
                register_a_value_exe_out !== a || register_b_value_exe_out !== b) begin
                n_fail++;
                $display("FAIL mul_result t=%0d: valid=%b res=%h required 1/%h",
                         t, out_valid, alu_result, ep);
            end
            tick;
        end
    endtask

    task automatic test_mul_stall;
        drive(1'b1, OP_MUL, 32'd7, 32'd9);
        tick;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (31) tick;
        n_checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mulstall_busy: busy=%b valid=%b required 1/0", busy, out_valid);
        end
        tick;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b1 || alu_result !== 32'd63) begin
            n_fail++;
            $display("FAIL mulstall_done: busy=%b valid=%b res=%0d required 0/1/63",
                     busy, out_valid, alu_result);
        end
        repeat (3) tick;
        n_checks++;
        if (out_valid !== 1'b1 || alu_result !== 32'd63 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL mulstall_hold: valid=%b res=%0d in_ready=%b required 1/63/0",
                     out_valid, alu_result, in_ready);
        end
        out_ready = 1'b1;
        tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mulstall_consume: valid=%b required 0", out_valid);
        end
    endtask
`endif

    task automatic test_flush;
        logic seen;
`ifdef STAGE_EXE_PIPE_MUL_EN
        out_ready = 1'b1;
        drive(1'b1, OP_MUL, $urandom | 32'd1, $urandom | 32'd1);
        tick;
        in_valid = 1'b0;
        repeat (9) tick;
        flush = 1'b1;
        drive(1'b1, OP_ADD, 32'd1, 32'd2); #1;
        n_checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_pre: busy=%b in_ready=%b required 1/0", busy, in_ready);
        end
        tick;
        flush = 1'b0; in_valid = 1'b0; #1;
        n_checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_mul: busy=%b valid=%b in_ready=%b required 0/0/1",
                     busy, out_valid, in_ready);
        end
        seen = 1'b0;
        repeat (40) begin
            tick;
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin
            n_fail++; $display("FAIL flush_no_result: emitted=%b required 0", seen);
        end
`endif
        out_ready = 1'b0;
        drive(1'b1, OP_ADD, 32'd8, 32'd9);
        tick;
        in_valid = 1'b0;
        flush = 1'b1;
        drive(1'b1, OP_ADD, 32'd2, 32'd2);
        tick;
        flush = 1'b0; in_valid = 1'b0;
        tick;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_output: valid=%b required 0", out_valid);
        end
        out_ready = 1'b1;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_backpressure;
        test_random_alu;
`ifdef STAGE_EXE_PIPE_MUL_EN
        test_mul;
        test_mul_stall;
`endif
        test_flush;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
